// File: rtl/ej32_xau.sv
// Multi-cycle extended arithmetic unit for the eJ32 data path (imul/idiv/irem/shifts).
// Result and divide-by-zero flag are registered and presented with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for req; single-cycle ops complete here
// MUL   | shift-add multiply, one multiplier bit per cycle (MUL_ITER=1 only)
// DIV   | restoring divide on unsigned magnitudes, one quotient bit per cycle
// FIX   | apply quotient/remainder sign and write r
module ej32_xau #(
  parameter int DSZ      = 32,
  parameter int SHW      = $clog2(DSZ),
  parameter int MUL_ITER = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic           flush,
  input  logic [2:0]     op,
  input  logic [DSZ-1:0] s,
  input  logic [DSZ-1:0] t,
  output logic           busy,
  output logic           done,
  output logic [DSZ-1:0] r,
  output logic           dz
);

  localparam logic [2:0] OP_IMUL  = 3'd0;
  localparam logic [2:0] OP_IDIV  = 3'd1;
  localparam logic [2:0] OP_IREM  = 3'd2;
  localparam logic [2:0] OP_ISHL  = 3'd3;
  localparam logic [2:0] OP_ISHR  = 3'd4;
  localparam logic [2:0] OP_IUSHR = 3'd5;

  localparam int            CW       = $clog2(DSZ) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DSZ);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            MUL_SEQ  = (MUL_ITER != 0);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t         state, state_nxt;
  logic [2:0]     op_q;
  logic [DSZ-1:0] a_q;
  logic [DSZ-1:0] b_q;
  logic [DSZ-1:0] acc_q;
  logic [CW-1:0]  cnt;
  logic           sgn_quo;
  logic           sgn_rem;

  logic           accept;
  logic           t_zero;
  logic           div_op;
  logic           last_step;
  logic [DSZ-1:0] s_mag;
  logic [DSZ-1:0] t_mag;
  logic [DSZ-1:0] quick_r;
  logic [DSZ-1:0] prod_step;
  logic [DSZ:0]   rem_shift;
  logic [DSZ:0]   rem_diff;
  logic           rem_ge;
  logic [DSZ-1:0] rem_step;
  logic [DSZ-1:0] quo_step;
  logic [DSZ-1:0] quo_fix;
  logic [DSZ-1:0] rem_fix;

  always_comb begin
    accept    = (state == IDLE) && req && !flush;
    t_zero    = (t == '0);
    div_op    = (op == OP_IDIV) || (op == OP_IREM);
    last_step = (cnt == CNT_ONE);
    // |MIN| wraps back to MIN, which is the correct unsigned magnitude 2^(DSZ-1)
    s_mag     = s[DSZ-1] ? -s : s;
    t_mag     = t[DSZ-1] ? -t : t;

    quick_r = t;
    case (op)
      OP_IMUL:          quick_r = s * t;
      OP_IDIV, OP_IREM: quick_r = '0;
      OP_ISHL:          quick_r = s << t[SHW-1:0];
      OP_ISHR:          quick_r = $signed(s) >>> t[SHW-1:0];
      OP_IUSHR:         quick_r = s >> t[SHW-1:0];
      default:          quick_r = t;
    endcase

    prod_step = acc_q + (b_q[0] ? a_q : '0);

    // acc_q stays below the divisor, so the shifted partial remainder fits DSZ+1 bits
    rem_shift = {acc_q, a_q[DSZ-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    rem_ge    = !rem_diff[DSZ];
    rem_step  = rem_ge ? rem_diff[DSZ-1:0] : rem_shift[DSZ-1:0];
    quo_step  = {a_q[DSZ-2:0], rem_ge};

    quo_fix = sgn_quo ? -a_q : a_q;
    rem_fix = sgn_rem ? -acc_q : acc_q;

    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if ((op == OP_IMUL) && MUL_SEQ) state_nxt = MUL;
          else if (div_op && !t_zero)     state_nxt = DIV;
        end
      end
      MUL: begin
        if (flush || last_step) state_nxt = IDLE;
      end
      DIV: begin
        if (flush)          state_nxt = IDLE;
        else if (last_step) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt     <= '0;
      sgn_quo <= 1'b0;
      sgn_rem <= 1'b0;
      r       <= '0;
      dz      <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op;
            cnt     <= CNT_LOAD;
            acc_q   <= '0;
            sgn_quo <= s[DSZ-1] ^ t[DSZ-1];
            sgn_rem <= s[DSZ-1];
            if (div_op) begin
              a_q <= s_mag;
              b_q <= t_mag;
            end else begin
              a_q <= s;
              b_q <= t;
            end
            if (state_nxt == IDLE) begin
              r    <= quick_r;
              dz   <= div_op && t_zero;
              done <= 1'b1;
            end
          end
        end
        MUL: begin
          if (!flush) begin
            acc_q <= prod_step;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt   <= cnt - 1'b1;
            if (last_step) begin
              r    <= prod_step;
              dz   <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        DIV: begin
          if (!flush) begin
            acc_q <= rem_step;
            a_q   <= quo_step;
            cnt   <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            r    <= (op_q == OP_IDIV) ? quo_fix : rem_fix;
            dz   <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
